rect_fill_engine: RTL and testbench

- Parametrised rectangle plot engine for the 160x120, 3-bit-colour VGA adapter path.
- On a Start strobe it fills one of NUM_POS fixed character slots, RECT_W x RECT_H pixels, one pixel per clock.
- Mode selects erase (background colour) or draw (caller colour).
- Sits between the game-control FSM and the VGA adapter's x/y/colour/writeEn inputs, and reports completion with a Busy/Done handshake.

---
 rtl/rect_fill_engine.sv | 168 ++++++++++++++++
 tb/tb_rect_fill_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: on Start, fills one fixed RECT_W x RECT_H character slot
// one pixel per clock toward the VGA adapter, then pulses Done.
module rect_fill_engine #(
  parameter int unsigned              RECT_W   = 9,
  parameter int unsigned              RECT_H   = 5,
  parameter int unsigned              NUM_POS  = 4,
  parameter int unsigned              POS_W    = 2,
  parameter logic [NUM_POS*8-1:0]     X_TABLE  = {8'd132, 8'd78, 8'd24, 8'd6},
  parameter int unsigned              Y_BASE   = 102,
  parameter logic [2:0]               BG_COLOR = 3'b011,
  parameter int unsigned              X_MAX    = 159,
  parameter int unsigned              Y_MAX    = 119
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [POS_W-1:0] PosSel,
  input  logic             Mode,
  input  logic [2:0]       ColorIn,
  output logic [7:0]       XOut,
  output logic [6:0]       YOut,
  output logic [2:0]       Color,
  output logic             Plot,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned XC_W = (RECT_W > 1) ? $clog2(RECT_W) : 1;
  localparam int unsigned YC_W = (RECT_H > 1) ? $clog2(RECT_H) : 1;
  localparam logic [POS_W:0]  NUM_POS_L = (POS_W+1)'(NUM_POS);
  localparam logic [XC_W-1:0] XC_LAST   = XC_W'(RECT_W - 1);
  localparam logic [YC_W-1:0] YC_LAST   = YC_W'(RECT_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [XC_W-1:0]  r_xc, w_xc_nxt;
  logic [YC_W-1:0]  r_yc, w_yc_nxt;
  logic [POS_W-1:0] r_slot, w_slot_nxt;
  logic             r_mode, w_mode_nxt;
  logic [2:0]       r_cin, w_cin_nxt;
  logic [7:0]       r_x, w_x_nxt;
  logic [6:0]       r_y, w_y_nxt;
  logic [2:0]       r_col, w_col_nxt;
  logic             r_plot, w_plot_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic [7:0]       w_base;
  logic [8:0]       w_px;
  logic [7:0]       w_py;
  logic             w_on_screen;
  logic             w_pos_ok;

  // Left-edge X of the latched slot
  always_comb begin
    w_base = '0;
    for (int i = 0; i < int'(NUM_POS); i++) begin
      if (r_slot == POS_W'(i)) w_base = X_TABLE[i*8 +: 8];
    end
  end

  assign w_px        = {1'b0, w_base} + 9'(r_xc);
  assign w_py        = 8'(Y_BASE) + 8'(r_yc);
  assign w_on_screen = (w_px <= 9'(X_MAX)) && (w_py <= 8'(Y_MAX));
  assign w_pos_ok    = ({1'b0, PosSel} < NUM_POS_L);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_xc    <= '0;
      r_yc    <= '0;
      r_slot  <= '0;
      r_mode  <= 1'b0;
      r_cin   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_col   <= '0;
      r_plot  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_xc    <= w_xc_nxt;
      r_yc    <= w_yc_nxt;
      r_slot  <= w_slot_nxt;
      r_mode  <= w_mode_nxt;
      r_cin   <= w_cin_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_col   <= w_col_nxt;
      r_plot  <= w_plot_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next state, scan counters and next output values
  always_comb begin
    w_state_nxt = r_state;
    w_xc_nxt    = r_xc;
    w_yc_nxt    = r_yc;
    w_slot_nxt  = r_slot;
    w_mode_nxt  = r_mode;
    w_cin_nxt   = r_cin;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_col_nxt   = r_col;
    w_plot_nxt  = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (w_pos_ok) begin
            w_state_nxt = S_FILL;
            w_slot_nxt  = PosSel;
            w_mode_nxt  = Mode;
            w_cin_nxt   = ColorIn;
            w_xc_nxt    = '0;
            w_yc_nxt    = '0;
            w_busy_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_FILL: begin
        w_busy_nxt = 1'b1;
        w_x_nxt    = w_px[7:0];
        w_y_nxt    = w_py[6:0];
        w_col_nxt  = r_mode ? r_cin : BG_COLOR;
        w_plot_nxt = w_on_screen;
        // Row-major scan; leave after the bottom-right pixel
        if (r_xc == XC_LAST) begin
          w_xc_nxt = '0;
          if (r_yc == YC_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_yc_nxt = r_yc + YC_W'(1);
          end
        end else begin
          w_xc_nxt = r_xc + XC_W'(1);
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign XOut  = r_x;
  assign YOut  = r_y;
  assign Color = r_col;
  assign Plot  = r_plot;
  assign Busy  = r_busy;
  assign Done  = r_done;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: default instance plus a 3-slot instance with an
// off-screen-crossing slot 0, both checked every cycle against a pixel-index model.
module tb_rect_fill_engine;

  localparam int W = 9;
  localparam int H = 5;
  localparam int N = W * H;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [1:0] PosSel = '0;
  logic       Mode = 1'b0;
  logic [2:0] ColorIn = '0;

  logic [7:0] xo [2];
  logic [6:0] yo [2];
  logic [2:0] co [2];
  logic       pl [2];
  logic       bu [2];
  logic       dn [2];

  always #5 Clock = ~Clock;

  rect_fill_engine u0 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .PosSel(PosSel), .Mode(Mode),
    .ColorIn(ColorIn), .XOut(xo[0]), .YOut(yo[0]), .Color(co[0]), .Plot(pl[0]),
    .Busy(bu[0]), .Done(dn[0])
  );

  rect_fill_engine #(
    .NUM_POS(3),
    .X_TABLE({8'd132, 8'd78, 8'd155})
  ) u1 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .PosSel(PosSel), .Mode(Mode),
    .ColorIn(ColorIn), .XOut(xo[1]), .YOut(yo[1]), .Color(co[1]), .Plot(pl[1]),
    .Busy(bu[1]), .Done(dn[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: phase k counts edges since an accepted Start; pixel index p = k-1
  int base [2][4] = '{'{6, 24, 78, 132}, '{155, 78, 132, 0}};
  int npos [2]    = '{4, 3};
  int k    [2]    = '{-1, -1};
  int slot [2];
  bit mmode[2];
  logic [2:0] mcol[2];
  logic [7:0] ex[2];
  logic [6:0] ey[2];
  logic [2:0] ec[2];
  bit ep[2], eb[2], ed[2], epix[2];
  bit erst  = 1'b1;
  bit armed = 1'b0;

  always @(posedge Clock) begin
    for (int j = 0; j < 2; j++) begin
      epix[j] = 0; ep[j] = 0; eb[j] = 0; ed[j] = 0;
      if (!Reset) begin
        k[j] = -1; ex[j] = '0; ey[j] = '0; ec[j] = '0;
      end else if (k[j] == -1 || k[j] == N + 1) begin
        k[j] = -1;
        if (Start) begin
          if (int'(PosSel) < npos[j]) begin
            k[j] = 0; slot[j] = int'(PosSel); mmode[j] = Mode; mcol[j] = ColorIn; eb[j] = 1;
          end else begin
            k[j] = -2;
          end
        end
      end else if (k[j] == -2) begin
        k[j] = N + 1; ed[j] = 1;
      end else begin
        k[j]++;
        if (k[j] <= N) begin
          int p, xi, yi;
          p  = k[j] - 1;
          xi = base[j][slot[j]] + p % W;
          yi = 102 + p / W;
          ex[j] = 8'(xi); ey[j] = 7'(yi);
          ec[j] = mmode[j] ? mcol[j] : 3'b011;
          ep[j] = (xi <= 159) && (yi <= 119);
          eb[j] = 1; epix[j] = 1;
        end else begin
          ed[j] = 1;
        end
      end
    end
    erst  = !Reset;
    armed = 1'b1;
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge Clock) begin
    if (armed) begin
      for (int j = 0; j < 2; j++) begin
        check($sformatf("u%0d_plot", j), 32'(pl[j]), 32'(ep[j]));
        check($sformatf("u%0d_busy", j), 32'(bu[j]), 32'(eb[j]));
        check($sformatf("u%0d_done", j), 32'(dn[j]), 32'(ed[j]));
        if (epix[j] || erst) begin
          check($sformatf("u%0d_x", j), 32'(xo[j]), 32'(ex[j]));
          check($sformatf("u%0d_y", j), 32'(yo[j]), 32'(ey[j]));
          check($sformatf("u%0d_color", j), 32'(co[j]), 32'(ec[j]));
        end
      end
    end
  end

  logic [7:0] px[N];
  logic [6:0] py[N];
  logic [2:0] pc[N];
  int np[2], nd[2], nb[2];
  bit got;

  // Issue one Start and observe u0 until its Done (bounded)
  task automatic run_fill(input bit hold, input bit chg, input logic [1:0] pos,
                          input logic m, input logic [2:0] c);
    PosSel = pos; Mode = m; ColorIn = c; Start = 1'b1;
    np = '{0, 0}; nd = '{0, 0}; nb = '{0, 0}; got = 0;
    for (int cyc = 0; cyc < N + 10 && !got; cyc++) begin
      @(negedge Clock);
      for (int j = 0; j < 2; j++) begin
        if (pl[j]) np[j]++;
        if (dn[j]) nd[j]++;
        if (bu[j]) nb[j]++;
      end
      if (cyc >= 1 && cyc <= N) begin
        px[cyc-1] = xo[0]; py[cyc-1] = yo[0]; pc[cyc-1] = co[0];
      end
      if (dn[0]) got = 1;
      if (!hold) Start = 1'b0;
      if (chg && cyc == 10) begin
        ColorIn = 3'b001; PosSel = ~pos; Mode = ~m;
      end
    end
    check("done_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge Clock);
      if (dn[0]) got = 1;
    end
    check("wait_done", 32'(got), 32'd1);
  endtask

  initial begin
    int bad, xmin, xmax, ymin, ymax, cnt;

    repeat (3) @(negedge Clock);
    check("rst_x", 32'(xo[0]), 32'd0);
    check("rst_busy", 32'(bu[0]), 32'd0);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    // Erase slot 0
    run_fill(0, 0, 2'd0, 1'b0, 3'b111);
    check("t1_plots_u0", 32'(np[0]), 32'd45);
    check("t1_plots_u1", 32'(np[1]), 32'd25);
    check("t1_first_x", 32'(px[0]), 32'd6);
    check("t1_first_y", 32'(py[0]), 32'd102);
    check("t1_10th_x", 32'(px[9]), 32'd6);
    check("t1_10th_y", 32'(py[9]), 32'd103);
    check("t1_last_x", 32'(px[44]), 32'd14);
    check("t1_last_y", 32'(py[44]), 32'd106);
    bad = 0;
    for (int i = 0; i < N; i++) if (pc[i] !== 3'b011) bad++;
    check("t1_bg_color", 32'(bad), 32'd0);
    @(negedge Clock);
    check("t1_busy_after", 32'(bu[0]), 32'd0);
    check("t1_done_after", 32'(dn[0]), 32'd0);

    // Draw slot 3 with a mid-fill colour change; slot 3 is illegal on u1
    run_fill(0, 1, 2'd3, 1'b1, 3'b100);
    xmin = 255; xmax = 0; ymin = 255; ymax = 0; bad = 0;
    for (int i = 0; i < N; i++) begin
      if (int'(px[i]) < xmin) xmin = int'(px[i]);
      if (int'(px[i]) > xmax) xmax = int'(px[i]);
      if (int'(py[i]) < ymin) ymin = int'(py[i]);
      if (int'(py[i]) > ymax) ymax = int'(py[i]);
      if (pc[i] !== 3'b100) bad++;
    end
    check("t2_plots", 32'(np[0]), 32'd45);
    check("t2_xmin", 32'(xmin), 32'd132);
    check("t2_xmax", 32'(xmax), 32'd140);
    check("t2_ymin", 32'(ymin), 32'd102);
    check("t2_ymax", 32'(ymax), 32'd106);
    check("t2_color", 32'(bad), 32'd0);
    check("t2_u1_plots", 32'(np[1]), 32'd0);
    check("t2_u1_dones", 32'(nd[1]), 32'd1);
    check("t2_u1_busy", 32'(nb[1]), 32'd0);
    repeat (2) @(negedge Clock);

    // Start held high throughout: one fill, then immediate restart after Done
    run_fill(1, 0, 2'd1, 1'b1, 3'b110);
    check("t3_plots", 32'(np[0]), 32'd45);
    check("t3_dones", 32'(nd[0]), 32'd1);
    @(negedge Clock);
    check("t3_restart_busy", 32'(bu[0]), 32'd1);
    Start = 1'b0;
    wait_done(N + 10);
    repeat (2) @(negedge Clock);

    // Reset at the 20th pixel, then a fresh fill
    PosSel = 2'd2; Mode = 1'b1; ColorIn = 3'b101; Start = 1'b1;
    cnt = 0;
    for (int i = 0; i < N + 10 && cnt < 20; i++) begin
      @(negedge Clock);
      Start = 1'b0;
      if (pl[0]) cnt++;
    end
    check("t4_reached_20", 32'(cnt), 32'd20);
    Reset = 1'b0;
    @(negedge Clock);
    check("t4_rst_plot", 32'(pl[0]), 32'd0);
    check("t4_rst_busy", 32'(bu[0]), 32'd0);
    check("t4_rst_done", 32'(dn[0]), 32'd0);
    check("t4_rst_x", 32'(xo[0]), 32'd0);
    check("t4_rst_y", 32'(yo[0]), 32'd0);
    check("t4_rst_color", 32'(co[0]), 32'd0);
    Reset = 1'b1;
    @(negedge Clock);
    run_fill(0, 0, 2'd2, 1'b1, 3'b101);
    check("t4_plots", 32'(np[0]), 32'd45);
    check("t4_first_x", 32'(px[0]), 32'd78);
    check("t4_first_y", 32'(py[0]), 32'd102);
    check("t4_first_color", 32'(pc[0]), 32'd5);

    // Random traffic, including stray Starts and occasional resets
    repeat (4000) begin
      @(negedge Clock);
      Start   = ($urandom_range(0, 3) == 0);
      PosSel  = 2'($urandom);
      Mode    = 1'($urandom);
      ColorIn = 3'($urandom);
      Reset   = ($urandom_range(0, 299) != 0);
    end
    @(negedge Clock);
    Reset = 1'b1; Start = 1'b0;
    repeat (N + 5) @(negedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
